fsm_seq_chk: RTL
================

# fsm_seq_chk

Parametrised packet-word checker FSM, successor to the fixed 16-bit par-mux checker. Each valid bus word must carry a header field in its top WORD_SIZE bits and a sequence number in its low WORD_SIZE bits. The block tracks the expected sequence and forwards good words. It flags header errors and sequence errors, and keeps saturating error counters. It sits between the parallel bus source and the downstream demux or serializer.

## Interface
- BUS_SIZE, 16, total word width; must be a multiple of WORD_SIZE and at least 2*WORD_SIZE.
- WORD_SIZE, 4, width of the header field and of the sequence field.
- HDR_VALUE, 4'hF, required header value (all ones by default).
- CNT_WIDTH, 8, width of each error counter.
- clk  input  1  sole clock, rising edge.
- reset  input  1  synchronous, active-low; state and outputs are initialised while 0.
- data_valid  input  1  bus_data_in carries a word this cycle.
- bus_data_in  input  BUS_SIZE  incoming word; header = [BUS_SIZE-1 -: WORD_SIZE], seq = [WORD_SIZE-1:0].
- clr_cnt  input  1  synchronous clear of both error counters.
- bus_data_out  output  BUS_SIZE  registered copy of the last good word, else 0.
- data_valid_out  output  1  registered; 1 for one cycle per good word.
- state  output  3  registered FSM state.
- nxt_state  output  3  combinational next state.
- error  output  1  registered; 1 while state is F_ERR or SEQ_ERR.
- nxt_error  output  1  combinational next value of error.
- f_err_cnt  output  CNT_WIDTH  saturating header-error count.
- seq_err_cnt  output  CNT_WIDTH  saturating sequence-error count.

## Operation
- State encoding: RESET=0, FIRST_PKT=1, REG_PKT=2, F_ERR=3, SEQ_ERR=4. Codes 5 to 7 are illegal and go to RESET on the next clock.
- Internal exp_seq register is WORD_SIZE bits wide and holds the expected sequence number.
- hdr_ok = (header == HDR_VALUE). seq_ok = (seq == exp_seq). seq0 = (seq == 0).
- data_valid=0: state, exp_seq and counters hold; data_valid_out=0; bus_data_out=0.
- The header check has priority: a word with a bad header and a bad sequence counts only as F_ERR.
- Transitions on a valid word:
  - Any state, !hdr_ok -> F_ERR.
  - RESET, F_ERR or SEQ_ERR, hdr_ok & seq0 -> FIRST_PKT, exp_seq <= 1.
  - RESET, F_ERR or SEQ_ERR, hdr_ok & !seq0 -> SEQ_ERR.
  - FIRST_PKT or REG_PKT, hdr_ok & seq_ok -> REG_PKT, exp_seq <= exp_seq+1.
  - FIRST_PKT or REG_PKT, hdr_ok & !seq_ok -> SEQ_ERR.
- The exp_seq increment wraps modulo 2^WORD_SIZE, so 15 -> 0 when WORD_SIZE=4. The wrapped value is still checked strictly.
- A good word is one whose next state is FIRST_PKT or REG_PKT. For a good word, bus_data_out <= bus_data_in and data_valid_out <= 1. Otherwise bus_data_out <= 0 and data_valid_out <= 0.
- An error word increments its counter by 1. Each counter saturates at 2^CNT_WIDTH-1.
- clr_cnt=1 zeroes both counters that cycle, overriding any same-cycle increment. State handling is unaffected.
- Reset values (reset=0 at a rising edge):
  - state=RESET, exp_seq=0, error=0, data_valid_out=0, bus_data_out=0, f_err_cnt=0, seq_err_cnt=0.
  - nxt_state and nxt_error show RESET and 0 while reset=0.
- Reset asserted mid-stream discards the in-flight word. The first word after release must have seq 0 to be good.

## Timing
- Latency is 1 clock: a word sampled at edge N appears on bus_data_out, state, error and the counters after edge N.
- nxt_state and nxt_error are combinational from the current inputs and state, and are valid before edge N.
- No backpressure: a word is accepted every cycle that data_valid=1, including back-to-back words.
- Recovery from either error state needs exactly one word with a good header and seq 0.
- The first cycle after reset release accepts a word.

## Test plan
- Reset: hold reset=0 for 11 cycles with random data_valid -> all outputs 0 and state=0 throughout; release, send 'hF000 -> state=1, data_valid_out=1, bus_data_out='hF000.
- Nominal sequence (BUS 16, WORD 4):
  - Stimulus: FFF0, FDD1, FEE9, FCC0, FBB1, F998, FAA0, A881, F770 back-to-back.
  - Required state: 1,2,4,1,2,4,1,3,1.
  - Required error: 0,0,1,0,0,1,0,1,0.
  - Required counters at end: seq_err_cnt=2, f_err_cnt=1.
- Wrap-around: send 'hF000 through 'hF00F, then 'hF000 -> 17 good words, state stays 2, zero errors. Then send 'hF002 -> state=4.
- Priority and hold:
  - Send 'h1239 while in REG_PKT -> state=3, f_err_cnt +1, seq_err_cnt unchanged.
  - Drop data_valid for 5 cycles -> state stays 3.
  - Send 'hF005 -> state=4.
  - Send 'hF000 -> state=1.
- Saturation and clear: CNT_WIDTH=2, send 5 bad-header words -> f_err_cnt=3. Assert clr_cnt while a bad word arrives -> f_err_cnt=0.
- Parametrisation: BUS_SIZE=32, WORD_SIZE=8, HDR_VALUE='hA5. Send 'hA5xxxx00, then 'hA5xxxx01, then 'hFFxxxx02 -> states 1, 2, 3.

Source files
------------

// File: rtl/fsm_seq_chk.sv
// +----------------------------------------------------------------------------+
// | fsm_seq_chk : header/sequence checker FSM for parallel bus words           |
// | Revision 1.0                                                                |
// +----------------------------------------------------------------------------+
`default_nettype none

module fsm_seq_chk #(
   parameter int                   BUS_SIZE  = 16,
   parameter int                   WORD_SIZE = 4,
   parameter logic [WORD_SIZE-1:0] HDR_VALUE = {WORD_SIZE{1'b1}},
   parameter int                   CNT_WIDTH = 8
) (
   input  logic                 clk_i,
   input  logic                 reset_i,
   input  logic                 data_valid_i,
   input  logic [BUS_SIZE-1:0]  bus_data_in_i,
   input  logic                 clr_cnt_i,
   output logic [BUS_SIZE-1:0]  bus_data_out_o,
   output logic                 data_valid_out_o,
   output logic [2:0]           state_o,
   output logic [2:0]           nxt_state_o,
   output logic                 error_o,
   output logic                 nxt_error_o,
   output logic [CNT_WIDTH-1:0] f_err_cnt_o,
   output logic [CNT_WIDTH-1:0] seq_err_cnt_o
);

   typedef enum logic [2:0] {
      S_RESET     = 3'd0,
      S_FIRST_PKT = 3'd1,
      S_REG_PKT   = 3'd2,
      S_F_ERR     = 3'd3,
      S_SEQ_ERR   = 3'd4
   } state_e;

   localparam logic [WORD_SIZE-1:0] SEQ_ONE = {{(WORD_SIZE-1){1'b0}}, 1'b1};
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

   state_e                 state_q, state_d;
   logic [WORD_SIZE-1:0]   exp_seq_q, exp_seq_d;
   logic                   error_q, error_d;
   logic                   dvo_q;
   logic [BUS_SIZE-1:0]    bus_q;
   logic [CNT_WIDTH-1:0]   f_cnt_q, seq_cnt_q;

   logic [WORD_SIZE-1:0]   w_hdr, w_seq;
   logic                   w_hdr_ok, w_seq_ok, w_seq0;
   logic                   w_good, w_f_inc, w_seq_inc;

   assign w_hdr    = bus_data_in_i[BUS_SIZE-1 -: WORD_SIZE];
   assign w_seq    = bus_data_in_i[WORD_SIZE-1:0];
   assign w_hdr_ok = (w_hdr == HDR_VALUE);
   assign w_seq_ok = (w_seq == exp_seq_q);
   assign w_seq0   = (w_seq == '0);

   // Header check is evaluated first in every state so it takes priority.
   always_comb begin
      state_d   = state_q;
      exp_seq_d = exp_seq_q;
      if (!reset_i) begin
         state_d   = S_RESET;
         exp_seq_d = '0;
      end else begin
         case (state_q)
            S_RESET, S_F_ERR, S_SEQ_ERR: begin
               if (data_valid_i) begin
                  if (!w_hdr_ok) begin
                     state_d = S_F_ERR;
                  end else if (w_seq0) begin
                     state_d   = S_FIRST_PKT;
                     exp_seq_d = SEQ_ONE;
                  end else begin
                     state_d = S_SEQ_ERR;
                  end
               end
            end
            S_FIRST_PKT, S_REG_PKT: begin
               if (data_valid_i) begin
                  if (!w_hdr_ok) begin
                     state_d = S_F_ERR;
                  end else if (w_seq_ok) begin
                     state_d   = S_REG_PKT;
                     exp_seq_d = exp_seq_q + SEQ_ONE;
                  end else begin
                     state_d = S_SEQ_ERR;
                  end
               end
            end
            default: begin
               state_d   = S_RESET;
               exp_seq_d = '0;
            end
         endcase
      end
   end

   assign error_d   = (state_d == S_F_ERR) || (state_d == S_SEQ_ERR);
   assign w_good    = reset_i && data_valid_i &&
                      ((state_d == S_FIRST_PKT) || (state_d == S_REG_PKT));
   assign w_f_inc   = reset_i && data_valid_i && (state_d == S_F_ERR);
   assign w_seq_inc = reset_i && data_valid_i && (state_d == S_SEQ_ERR);

   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         state_q   <= S_RESET;
         exp_seq_q <= '0;
         error_q   <= 1'b0;
         dvo_q     <= 1'b0;
         bus_q     <= '0;
         f_cnt_q   <= '0;
         seq_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         exp_seq_q <= exp_seq_d;
         error_q   <= error_d;
         dvo_q     <= w_good;
         bus_q     <= w_good ? bus_data_in_i : '0;
         if (clr_cnt_i) begin
            f_cnt_q   <= '0;
            seq_cnt_q <= '0;
         end else begin
            if (w_f_inc && (f_cnt_q != CNT_MAX))
               f_cnt_q <= f_cnt_q + CNT_ONE;
            if (w_seq_inc && (seq_cnt_q != CNT_MAX))
               seq_cnt_q <= seq_cnt_q + CNT_ONE;
         end
      end
   end

   assign bus_data_out_o   = bus_q;
   assign data_valid_out_o = dvo_q;
   assign state_o          = state_q;
   assign nxt_state_o      = state_d;
   assign error_o          = error_q;
   assign nxt_error_o      = error_d;
   assign f_err_cnt_o      = f_cnt_q;
   assign seq_err_cnt_o    = seq_cnt_q;

endmodule

`default_nettype wire
